// File: rtl/uart_rx_os16_if.sv
// Receive-side bundle between uart_rx_os16 and its byte consumer.
// The receiver drives data, status pulses and busy; the consumer drives ready.
interface uart_rx_os16_if;
    logic [7:0] dout_rx;
    logic       valid;
    logic       ready;
    logic       done_rx;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    modport master (
        output dout_rx,
        output valid,
        input  ready,
        output done_rx,
        output frame_err,
        output overrun,
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        output busy
    );

    modport slave (
        input  dout_rx,
        input  valid,
        output ready,
        input  done_rx,
        input  frame_err,
        input  overrun,
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        input  busy
    );
endinterface

// File: rtl/uart_rx_os16.sv
// 16x-oversampled 8N1 UART receiver, 3-sample majority vote; parity via UART_RX_PARITY_EN.
// Latency: start edge to done_rx/valid ~ 2 + 16*OS_DIV*9.5 cycles.
// Backpressure: one-entry buffer; a good frame arriving while full is dropped and flagged overrun.
module uart_rx_os16 #(
    parameter int clk_freq = 1000000,
    parameter int baud     = 9600
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    uart_rx_os16_if.master out_if
);

    localparam int OS_DIV = clk_freq / (baud * 16);
    localparam int TW     = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;

    if (OS_DIV < 1) begin : g_os_div_check
        $error("uart_rx_os16: clk_freq/(baud*16) must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef UART_RX_PARITY_EN
        ,
        S_PARITY
`endif
    } state_t;

    state_t          state_q, state_d;
    logic            rx_meta_q, rx_meta_d;
    logic            rx_s_q, rx_s_d;
    logic            armed_q, armed_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [3:0]      os_cnt_q, os_cnt_d;
    logic [3:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            s7_q, s7_d;
    logic            s8_q, s8_d;
    logic [7:0]      dout_q, dout_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;
    logic            busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic            par_bad_q, par_bad_d;
    logic            perr_q, perr_d;
`endif

    logic os_tick;
    logic mid;
    logic wrap;
    logic maj;
    logic good;
    logic hs;

    assign os_tick = (tick_q == TW'(OS_DIV - 1));
    assign mid     = os_tick && (os_cnt_q == 4'd9);
    assign wrap    = os_tick && (os_cnt_q == 4'd15);
    assign maj     = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);
    assign hs      = valid_q & out_if.ready;

    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        state_d   = state_q;
        armed_d   = armed_q;
        tick_d    = os_tick ? '0 : tick_q + TW'(1);
        os_cnt_d  = os_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        s7_d      = s7_q;
        s8_d      = s8_q;
        dout_d    = dout_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        good      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif

        if (state_q != S_IDLE && os_tick) begin
            os_cnt_d = os_cnt_q + 4'd1;
            if (os_cnt_q == 4'd7) s7_d = rx_s_q;
            if (os_cnt_q == 4'd8) s8_d = rx_s_q;
        end

        case (state_q)
            S_IDLE: begin
                os_cnt_d = '0;
                if (rx_s_q) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d  = S_START;
                    tick_d   = '0;
                    os_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            S_START: begin
                if (mid) begin
                    if (!maj) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                // bit_idx 0 is the tail of the start bit; data bit n lives at index n+1
                if (mid && bit_idx_q != 4'd0) shift_d = {maj, shift_q[7:1]};
                if (wrap) begin
                    if (bit_idx_q == 4'd8) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (mid) par_bad_d = (maj != ((^shift_q) ^ PARITY_ODD));
                if (wrap) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (mid) begin
                    state_d = S_IDLE;
                    armed_d = 1'b0;
                    ferr_d  = ~maj;
`ifdef UART_RX_PARITY_EN
                    perr_d  = par_bad_q;
                    good    = maj & ~par_bad_q;
`else
                    good    = maj;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (hs) valid_d = 1'b0;
        if (good) begin
            done_d = 1'b1;
            if (!valid_q || hs) begin
                dout_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            armed_q   <= 1'b0;
            tick_q    <= '0;
            os_cnt_q  <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            s7_q      <= 1'b0;
            s8_q      <= 1'b0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            armed_q   <= armed_d;
            tick_q    <= tick_d;
            os_cnt_q  <= os_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            s7_q      <= s7_d;
            s8_q      <= s8_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign out_if.dout_rx   = dout_q;
    assign out_if.valid     = valid_q;
    assign out_if.done_rx   = done_q;
    assign out_if.frame_err = ferr_q;
    assign out_if.overrun   = ovr_q;
    assign out_if.busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign out_if.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: random bytes on a serial line, checked against a frame-level model
// of the receiver's output buffer and status pulses.
module tb_uart_rx_os16;
    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 10000;
    localparam int BIT_CLK  = 160;
    localparam bit P_ODD    = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    uart_rx_os16_if dut_if ();

    uart_rx_os16 #(
        .clk_freq (CLK_FREQ),
`ifdef UART_RX_PARITY_EN
        .PARITY_ODD (P_ODD),
`endif
        .baud     (BAUD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .out_if (dut_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // observed side
    int cnt_done = 0, cnt_ferr = 0, cnt_ovr = 0, cnt_vcyc = 0;
    logic [7:0] got_q[$];
`ifdef UART_RX_PARITY_EN
    int cnt_perr = 0;
    int exp_perr = 0;
`endif

    // frame-level reference: a one-entry mailbox plus event counters
    int exp_done = 0, exp_ferr = 0, exp_ovr = 0;
    logic       mdl_valid = 1'b0;
    logic [7:0] mdl_dout  = 8'h00;
    logic       mdl_ready = 1'b1;
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (dut_if.done_rx)   cnt_done++;
            if (dut_if.frame_err) cnt_ferr++;
            if (dut_if.overrun)   cnt_ovr++;
`ifdef UART_RX_PARITY_EN
            if (dut_if.parity_err) cnt_perr++;
`endif
            if (dut_if.valid) begin
                cnt_vcyc++;
                if (dut_if.ready) got_q.push_back(dut_if.dout_rx);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_frame(input logic [7:0] b, input logic stop_ok, input logic par_ok);
        if (!stop_ok) exp_ferr++;
`ifdef UART_RX_PARITY_EN
        if (!par_ok) exp_perr++;
`endif
        if (stop_ok && par_ok) begin
            exp_done++;
            if (mdl_valid) begin
                exp_ovr++;
            end else begin
                mdl_valid = 1'b1;
                mdl_dout  = b;
            end
        end
        if (mdl_ready && mdl_valid) begin
            exp_q.push_back(mdl_dout);
            mdl_valid = 1'b0;
        end
    endfunction

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT_CLK) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_raw(input logic [7:0] b, input logic par_bit, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_bit);
`else
        if (par_bit !== 1'bx) ;
`endif
        drive_bit(stop_bit);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic par;
        par = (^b) ^ P_ODD;
        send_raw(b, par, stop_bit);
        model_frame(b, stop_bit, 1'b1);
    endtask

    task automatic compare_all(input string tag);
        int n;
        check({tag, "_done"}, cnt_done, exp_done);
        check({tag, "_ferr"}, cnt_ferr, exp_ferr);
        check({tag, "_ovr"}, cnt_ovr, exp_ovr);
`ifdef UART_RX_PARITY_EN
        check({tag, "_perr"}, cnt_perr, exp_perr);
`endif
        check({tag, "_valid"}, dut_if.valid, mdl_valid);
        check({tag, "_dout"}, dut_if.dout_rx, mdl_dout);
        check({tag, "_nbytes"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_byte"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] a, b;
        int v0;
        dut_if.ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_dout", dut_if.dout_rx, 8'h00);
        check("rst_valid", dut_if.valid, 1'b0);
        check("rst_busy", dut_if.busy, 1'b0);
        check("rst_done", dut_if.done_rx, 1'b0);
        check("rst_ferr", dut_if.frame_err, 1'b0);
        check("rst_ovr", dut_if.overrun, 1'b0);
        idle(20);

        // basic 0xA5: valid must be up for exactly one cycle with ready held high
        v0 = cnt_vcyc;
        send_frame(8'hA5, 1'b1);
        idle(20);
        check("a5_vcyc", cnt_vcyc - v0, 1);
        compare_all("a5");

        for (int k = 0; k < 6; k++) begin
            a = 8'($urandom);
            send_frame(a, 1'b1);
            idle($urandom_range(5, 200));
        end
        compare_all("rand");

        // short low pulse is a glitch, not a start bit
        rx = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        idle(100);
        check("glitch_busy", dut_if.busy, 1'b0);
        compare_all("glitch");

        // framing error followed by a held break
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        repeat (3000) @(posedge clk);
        #1;
        compare_all("break");
        idle(200);
        send_frame(8'h81, 1'b1);
        idle(20);
        compare_all("after_break");

        // consumer stalled: second frame overruns
        dut_if.ready = 1'b0;
        mdl_ready    = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        send_frame(a, 1'b1);
        idle(50);
        send_frame(b, 1'b1);
        idle(50);
        compare_all("stall");
        dut_if.ready = 1'b1;
        mdl_ready    = 1'b1;
        if (mdl_valid) begin
            exp_q.push_back(mdl_dout);
            mdl_valid = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        compare_all("drain");

        // reset in the middle of data bit 4
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        repeat (BIT_CLK / 2) @(posedge clk);
        #1;
        check("mid_busy", dut_if.busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rx  = 1'b1;
        mdl_valid = 1'b0;
        mdl_dout  = 8'h00;
        @(negedge clk);
        check("mrst_busy", dut_if.busy, 1'b0);
        check("mrst_done", dut_if.done_rx, 1'b0);
        check("mrst_ferr", dut_if.frame_err, 1'b0);
        compare_all("mrst");
        idle(200);
        send_frame(8'h5A, 1'b1);
        idle(20);
        compare_all("post_rst");

`ifdef UART_RX_PARITY_EN
        send_raw(8'h07, 1'b0, 1'b1);
        model_frame(8'h07, 1'b1, 1'b0 == ((^8'h07) ^ P_ODD));
        idle(20);
        compare_all("par_bad");
        send_raw(8'h07, 1'b1, 1'b1);
        model_frame(8'h07, 1'b1, 1'b1 == ((^8'h07) ^ P_ODD));
        idle(20);
        compare_all("par_good");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
